// File: rtl/btn_press_classifier.sv
// Turns a debounced button level into one-cycle short, long and auto-repeat pulses.
// A button already held at reset is ignored until it has been seen released once.
module btn_press_classifier #(
    parameter int unsigned LONG_PRESS_CYCLES = 100_000_000,
    parameter int unsigned REPEAT_CYCLES     = 20_000_000,
    parameter bit          REPEAT_EN         = 1'b1,
    parameter int unsigned CNT_WIDTH         = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        WAIT_RELEASE,
        IDLE,
        PRESSED,
        LONG_HELD
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 short_next;
    logic                 long_next;
    logic                 repeat_next;
    logic                 held_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_RELEASE;
            cnt          <= '0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            short_pulse  <= short_next;
            long_pulse   <= long_next;
            repeat_pulse <= repeat_next;
            held         <= held_next;
        end
    end

    // A release always takes priority over a threshold reached on the same edge.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        short_next  = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;

        case (state)
            WAIT_RELEASE: begin
                if (!btn_level) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end

            IDLE: begin
                if (btn_level) begin
                    state_next = PRESSED;
                    cnt_next   = CNT_ONE;
                end
            end

            PRESSED: begin
                if (!btn_level) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    short_next = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_next = LONG_HELD;
                    cnt_next   = '0;
                    long_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            LONG_HELD: begin
                if (!btn_level) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == REPEAT_LAST) begin
                    // Without auto-repeat the counter parks here instead of wrapping.
                    if (REPEAT_EN) begin
                        repeat_next = 1'b1;
                        cnt_next    = '0;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            default: begin
                state_next = WAIT_RELEASE;
                cnt_next   = '0;
            end
        endcase

        held_next = (state_next == PRESSED) || (state_next == LONG_HELD);
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier: two instances (repeat on/off) share one stimulus
// and are compared every cycle against a press-length model, plus literal event counts.
module tb_btn_press_classifier;

    localparam int L = 10;
    localparam int R = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_level;
    logic short_a, long_a, repeat_a, held_a;
    logic short_b, long_b, repeat_b, held_b;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    int n_short_a = 0, n_long_a = 0, n_repeat_a = 0, n_held_a = 0;
    int n_short_b = 0, n_long_b = 0, n_repeat_b = 0, n_held_b = 0;

    bit armed = 1'b0;
    int run   = 0;
    bit exp_short = 1'b0, exp_long = 1'b0, exp_repeat = 1'b0, exp_held = 1'b0;

    always #5 clk = ~clk;

    btn_press_classifier #(
        .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1), .CNT_WIDTH(W)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
        .short_pulse(short_a), .long_pulse(long_a), .repeat_pulse(repeat_a), .held(held_a)
    );

    btn_press_classifier #(
        .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0), .CNT_WIDTH(W)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
        .short_pulse(short_b), .long_pulse(long_b), .repeat_pulse(repeat_b), .held(held_b)
    );

    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, required %0d", name, cycle, actual, required);
        end
    endtask

    // Model: count consecutive high samples of a press; events follow from the count.
    always @(posedge clk or negedge rst_n) begin
        exp_short  = 1'b0;
        exp_long   = 1'b0;
        exp_repeat = 1'b0;
        if (!rst_n) begin
            armed = 1'b0;
            run   = 0;
        end else if (!btn_level) begin
            if (armed && run > 0 && run < L) exp_short = 1'b1;
            armed = 1'b1;
            run   = 0;
        end else if (armed) begin
            run++;
            if (run == L) exp_long = 1'b1;
            if (run > L && ((run - L) % R) == 0) exp_repeat = 1'b1;
        end
        exp_held = armed && (run > 0);
    end

    always @(negedge clk) begin
        cycle++;
        n_short_a  += int'(short_a);
        n_long_a   += int'(long_a);
        n_repeat_a += int'(repeat_a);
        n_held_a   += int'(held_a);
        n_short_b  += int'(short_b);
        n_long_b   += int'(long_b);
        n_repeat_b += int'(repeat_b);
        n_held_b   += int'(held_b);
        checkOutput("a.short_pulse",  int'(short_a),  int'(exp_short));
        checkOutput("a.long_pulse",   int'(long_a),   int'(exp_long));
        checkOutput("a.repeat_pulse", int'(repeat_a), int'(exp_repeat));
        checkOutput("a.held",         int'(held_a),   int'(exp_held));
        checkOutput("b.short_pulse",  int'(short_b),  int'(exp_short));
        checkOutput("b.long_pulse",   int'(long_b),   int'(exp_long));
        checkOutput("b.repeat_pulse", int'(repeat_b), 0);
        checkOutput("b.held",         int'(held_b),   int'(exp_held));
    end

    task automatic applyStimulus(input int lows_before, input int highs, input int lows_after);
        repeat (lows_before) begin @(negedge clk); btn_level = 1'b0; end
        repeat (highs)       begin @(negedge clk); btn_level = 1'b1; end
        repeat (lows_after)  begin @(negedge clk); btn_level = 1'b0; end
    endtask

    task automatic run_case(input string name, input int lows_before, input int highs,
                            input int lows_after, input int presses,
                            input int want_short, input int want_long,
                            input int want_repeat_a, input int want_held);
        int s_a, l_a, r_a, h_a, s_b, l_b, r_b, h_b;
        s_a = n_short_a; l_a = n_long_a; r_a = n_repeat_a; h_a = n_held_a;
        s_b = n_short_b; l_b = n_long_b; r_b = n_repeat_b; h_b = n_held_b;
        applyStimulus(lows_before, highs, lows_after);
        for (int p = 1; p < presses; p++) applyStimulus(0, highs, lows_after);
        repeat (2) @(negedge clk);
        #1;
        checkOutput({name, " short count a"},  n_short_a - s_a,  want_short);
        checkOutput({name, " long count a"},   n_long_a - l_a,   want_long);
        checkOutput({name, " repeat count a"}, n_repeat_a - r_a, want_repeat_a);
        checkOutput({name, " held cycles a"},  n_held_a - h_a,   want_held);
        checkOutput({name, " short count b"},  n_short_b - s_b,  want_short);
        checkOutput({name, " long count b"},   n_long_b - l_b,   want_long);
        checkOutput({name, " repeat count b"}, n_repeat_b - r_b, 0);
        checkOutput({name, " held cycles b"},  n_held_b - h_b,   want_held);
    endtask

    initial begin
        int s0, l0, r0, h0;
        rst_n     = 1'b1;
        btn_level = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        checkOutput("reset short_pulse",  int'(short_a),  0);
        checkOutput("reset long_pulse",   int'(long_a),   0);
        checkOutput("reset repeat_pulse", int'(repeat_a), 0);
        checkOutput("reset held",         int'(held_a),   0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;

        $display("[TB] button held through reset");
        run_case("stuck_at_reset", 0, 6, 0, 1, 0, 0, 0, 0);
        $display("[TB] short presses and thresholds");
        run_case("press3",  1, 3,  3, 1, 1, 0, 0, 3);
        run_case("press9",  0, 9,  3, 1, 1, 0, 0, 9);
        run_case("press10", 0, 10, 3, 1, 0, 1, 0, 10);
        run_case("press13", 0, 13, 3, 1, 0, 1, 0, 13);
        run_case("press22", 0, 22, 3, 1, 0, 1, 3, 22);
        run_case("back_to_back", 0, 3, 1, 2, 2, 0, 0, 6);

        $display("[TB] reset during a long hold");
        applyStimulus(0, 12, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset short_pulse",  int'(short_a),  0);
        checkOutput("midreset long_pulse",   int'(long_a),   0);
        checkOutput("midreset repeat_pulse", int'(repeat_a), 0);
        checkOutput("midreset held a",       int'(held_a),   0);
        checkOutput("midreset held b",       int'(held_b),   0);
        s0 = n_short_a; l0 = n_long_a; r0 = n_repeat_a; h0 = n_held_a;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("post-reset hold events", (n_short_a - s0) + (n_long_a - l0) + (n_repeat_a - r0), 0);
        checkOutput("post-reset hold held",   n_held_a - h0, 0);
        run_case("fresh_press", 1, 3, 3, 1, 1, 0, 0, 3);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/btn_press_classifier.md
# btn_press_classifier

Consumes one debounced, active-high button level and turns it into single-cycle event pulses: a short press on release, a long press once the hold threshold is reached, and optional auto-repeat while held. It sits between the per-button debouncer and the game/menu control FSMs, so those FSMs never time button levels themselves. Everything is on a single clock domain.

## Interface
- LONG_PRESS_CYCLES, 100_000_000: hold length, in clk edges, that qualifies a long press (1 s at 100 MHz); must be ≥ 2.
- REPEAT_CYCLES, 20_000_000: period between repeat pulses once long-held; must be ≥ 2.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 suppresses repeat_pulse entirely.
- CNT_WIDTH, 27: counter width; must satisfy 2^CNT_WIDTH > max(LONG_PRESS_CYCLES, REPEAT_CYCLES).
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_level  input  1  debounced button level (1 = pressed), synchronous to clk.
- short_pulse  output  1  one-cycle pulse: button released before the long threshold.
- long_pulse  output  1  one-cycle pulse: long threshold reached while still held.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while in long hold.
- held  output  1  level, 1 while a press is being tracked (PRESSED or LONG_HELD).

## Operation
- All outputs are registered. Reset forces every output to 0, cnt to 0, and state to WAIT_RELEASE.
- States: WAIT_RELEASE, IDLE, PRESSED, LONG_HELD.
- WAIT_RELEASE: ignores btn_level=1. On the first edge that samples btn_level=0, go to IDLE. This prevents a button that is already down at reset from producing any event.
- IDLE: on sampling btn_level=1, go to PRESSED with cnt←1.
- PRESSED, btn_level=0: go to IDLE and assert short_pulse for the next cycle.
- PRESSED, btn_level=1 and cnt==LONG_PRESS_CYCLES−1: go to LONG_HELD, cnt←0, assert long_pulse.
- PRESSED, btn_level=1, otherwise: cnt←cnt+1.
- LONG_HELD, btn_level=0: go to IDLE. No short_pulse and no other pulse is produced.
- LONG_HELD, btn_level=1, REPEAT_EN=1, cnt==REPEAT_CYCLES−1: assert repeat_pulse and set cnt←0.
- LONG_HELD, btn_level=1, otherwise: cnt←cnt+1. With REPEAT_EN=0, cnt saturates at REPEAT_CYCLES−1 and never wraps.
- held is 1 exactly when the registered state is PRESSED or LONG_HELD.
- At most one of short/long/repeat_pulse is high in any cycle.
- Pulses never stretch beyond one cycle, even if the state is unchanged.

## Timing
- Latency: let edge t be the first edge that samples btn_level=1 in IDLE.
  - held rises after edge t.
  - long_pulse is high for the single cycle following edge t+LONG_PRESS_CYCLES−1, i.e. after the LONG_PRESS_CYCLES-th consecutive high sample.
  - repeat_pulse then follows every REPEAT_CYCLES edges: the first after edge t+LONG_PRESS_CYCLES−1+REPEAT_CYCLES.
- Release: short_pulse is high in the cycle after the edge that samples btn_level=0 in PRESSED; held falls at that same edge.
- Simultaneous events (release wins):
  - A release sampled on the edge where cnt==LONG_PRESS_CYCLES−1 gives short_pulse, not long_pulse.
  - A release on a repeat-expiry edge gives no repeat_pulse.
- A press sampled on the edge right after a release, with IDLE held for one cycle, starts a new press normally. There is no lockout.
- Reset mid-operation: outputs drop to 0 asynchronously and any pending pulse is discarded. If btn_level stays 1, no event occurs until a 0 is sampled and a fresh press begins.

## Test plan
Use LONG_PRESS_CYCLES=10, REPEAT_CYCLES=4, REPEAT_EN=1 unless stated.
- Hold btn_level=1 for 3 edges, then 0: exactly one short_pulse, one cycle after the release edge; held high for 3 cycles; no long_pulse or repeat_pulse.
- Hold for exactly 9 edges, then release: short_pulse only.
- Hold for exactly 10 edges, then release: long_pulse after the 10th edge, no short_pulse on release, held falls after the release edge.
- Hold for 22 edges: long_pulse after edge 10, repeat_pulse after edges 14, 18 and 22 (three repeats), all one cycle wide.
- Repeat the previous hold with REPEAT_EN=0: one long_pulse, zero repeat_pulse, held stays high until release.
- Assert rst_n=0 at edge 12 of a hold while btn_level stays 1:
  - All outputs go to 0 immediately and stay there while the button remains high.
  - After btn_level=0 for 1 edge, a 3-edge press yields one short_pulse.
  - Also pulse rst_n=0 with btn_level=1 from time 0: no events are produced until a release is seen.
